ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-port front end sharing the single-port 256-word data RAM between two requesters.
- Port 0: CPU load/store unit. Port 1: program loader / debug port.
- Serialises accesses with a req/ack handshake and round-robin priority on conflict.
- Drives the RAM's address, write-data and write-enable pins and registers returned read data per port.

Parameters:
- WIDTH, 16, data word width; must match the RAM data width.
- ADDR_W, 8, RAM address width (256 words).

Ports:
- CPUclk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r0_req  in  1  port 0 request; held with its command until r0_ack.
- r0_we  in  1  port 0 write (1) / read (0).
- r0_addr  in  ADDR_W  port 0 address.
- r0_wdata  in  WIDTH  port 0 write data.
- r0_ack  out  1  port 0 one-cycle completion pulse.
- r0_rdata  out  WIDTH  port 0 read data; valid while r0_ack is high and held after.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata: same as port 0, for port 1.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_wdata  out  WIDTH  to RAM wdata.
- ram_we  out  1  to RAM we.
- ram_rdata  in  WIDTH  from RAM rdata (combinational read).
- gnt  out  2  one-hot owner of the current transaction; 0 when idle.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ram_we=0; ram_addr=0; ram_wdata=0.
  - r0_ack=r1_ack=0; r0_rdata=r1_rdata=0; gnt=0.
  - last-served pointer=1, so port 0 wins the first tie.
- States: IDLE -> SERVE -> ACK -> IDLE. One transaction per 3 cycles max.
- IDLE:
  - No req: stay.
  - Exactly one req: grant it.
  - Both req: grant the port that is not last-served.
  - On grant, at the clock edge: latch that port's we/addr/wdata into command registers; set gnt; update last-served; go to SERVE.
- SERVE:
  - ram_addr/ram_wdata come from the command registers; ram_we=cmd_we (combinational from state; never high outside SERVE).
  - At the edge: the RAM write commits; on a read, the granted port's rdata <= ram_rdata; the granted port's ack <= 1; go to ACK.
  - On a write, rdata holds its previous value.
- ACK:
  - Granted ack is high for exactly this cycle. Both req inputs are ignored.
  - At the edge: ack <= 0; gnt <= 0; go to IDLE.
  - The requester must drop req or present its next command by this edge. A req still high in IDLE is a new transaction.
- Latency: req sampled at edge N -> ack high in cycle N+2 -> earliest next grant sampled at edge N+3.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1. Each port waits at most 3 extra cycles.
- A requester dropping req after grant: the transaction still completes and ack still pulses (command is latched).
- Addresses wrap naturally at ADDR_W bits; no range checking.
- Reset mid-SERVE: ram_we drops immediately, the write is lost, no ack is issued, and the pointer returns to its reset value.
- ram_addr/ram_wdata hold the last command values in IDLE/ACK. The RAM ignores them because ram_we=0.

Decomposition:
- Package ram_arb_pkg:
  - state enum {IDLE, SERVE, ACK} (2 bits).
  - default WIDTH/ADDR_W constants.
  - port index constants P_CPU=0, P_LOAD=1.
- Sub-module rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: one-hot pick, valid.
  - Reused by later multi-master blocks.
- FSM, command registers and per-port rdata/ack registers live in ram_arbiter.

Test Plan:
- Single write then read on port 0:
  - Stimulus: r0 write addr 0x10 data 0xBEEF, then r0 read addr 0x10.
  - Required: ram_we high exactly one cycle; each ack arrives 2 cycles after req sample; r0_rdata=0xBEEF.
- Simultaneous requests after reset:
  - Stimulus: r0 and r1 both read (addr 0x01 / 0x02).
  - Required: port 0 is served first (gnt=01), then port 1 (gnt=10); acks 3 cycles apart.
- Continuous contention:
  - Stimulus: both ports re-request immediately after every ack for 8 transactions.
  - Required: grant order is 0,1,0,1,0,1,0,1; no port gets two consecutive grants.
- Write does not disturb rdata:
  - Stimulus: r1 reads 0x20 (=0x1234), then r1 writes 0x20 with 0x5678.
  - Required: r1_rdata stays 0x1234 through the write ack; a read afterwards returns 0x5678.
- Reset mid-SERVE:
  - Stimulus: assert rst_n=0 during the SERVE cycle of r0 write 0x30 / 0xAAAA.
  - Required: ram_we drops at once; no r0_ack; memory[0x30] unchanged; the next tie after release grants port 0.
- Address wrap:
  - Stimulus: write 0xFF with 0x0001, then read 0xFF and 0x00.
  - Required: values are independent; no aliasing.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the data-RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_ADDR_W = 8;

    localparam int P_CPU  = 0;
    localparam int P_LOAD = 1;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker; on a tie the port that
// was not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick,
    output logic       valid
);

    always_comb begin
        pick  = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
        valid = |req;
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises two req/ack requesters onto the single-port data RAM,
// one transaction per IDLE -> SERVE -> ACK pass, round-robin on conflict.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CPUclk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [WIDTH-1:0]  r0_wdata,
    output logic              r0_ack,
    output logic [WIDTH-1:0]  r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [WIDTH-1:0]  r1_wdata,
    output logic              r1_ack,
    output logic [WIDTH-1:0]  r1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_wdata,
    output logic              ram_we,
    input  logic [WIDTH-1:0]  ram_rdata,
    output logic [1:0]        gnt
);

    state_t            state, state_nx;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [WIDTH-1:0]  cmd_wdata;
    logic              last;
    logic [1:0]        pick;
    logic              valid;

    rr_pick2 u_pick (
        .req   ({r1_req, r0_req}),
        .last  (last),
        .pick  (pick),
        .valid (valid)
    );

    always_ff @(posedge CPUclk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE)  ? (valid ? SERVE : IDLE) :
                   (state == SERVE) ? ACK : IDLE;
    end

    // Reset returns last to port 1 so port 0 wins the first tie.
    always_ff @(posedge CPUclk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            last      <= 1'b1;
            gnt       <= 2'b00;
            r0_ack    <= 1'b0;
            r1_ack    <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: if (valid) begin
                    cmd_we    <= pick[P_LOAD] ? r1_we    : r0_we;
                    cmd_addr  <= pick[P_LOAD] ? r1_addr  : r0_addr;
                    cmd_wdata <= pick[P_LOAD] ? r1_wdata : r0_wdata;
                    gnt       <= pick;
                    last      <= pick[P_LOAD];
                end
                SERVE: begin
                    r0_ack <= gnt[P_CPU];
                    r1_ack <= gnt[P_LOAD];
                    if (gnt[P_CPU] && !cmd_we)
                        r0_rdata <= ram_rdata;
                    if (gnt[P_LOAD] && !cmd_we)
                        r1_rdata <= ram_rdata;
                end
                ACK: begin
                    r0_ack <= 1'b0;
                    r1_ack <= 1'b0;
                    gnt    <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    // Write enable is decoded from state so an async reset kills it at once.
    always_comb begin
        ram_we    = (state == SERVE) && cmd_we;
        ram_addr  = cmd_addr;
        ram_wdata = cmd_wdata;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of the data-RAM arbiter against a
// behavioural 256-word RAM with combinational read.
module tb_ram_arbiter;

    logic        CPUclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [7:0]  r0_addr = '0;
    logic [15:0] r0_wdata = '0;
    logic        r0_ack;
    logic [15:0] r0_rdata;
    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [7:0]  r1_addr = '0;
    logic [15:0] r1_wdata = '0;
    logic        r1_ack;
    logic [15:0] r1_rdata;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic        ram_we;
    logic [1:0]  gnt;
    logic [15:0] mem [256];
    logic        mem_clr = 1'b1;
    int          total = 0;
    int          bad = 0;

    ram_arbiter dut (
        .CPUclk    (CPUclk),
        .rst_n     (rst_n),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_ack    (r0_ack),
        .r0_rdata  (r0_rdata),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_ack    (r1_ack),
        .r1_rdata  (r1_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .gnt       (gnt)
    );

    always #5 CPUclk = ~CPUclk;

    always @(posedge CPUclk) begin
        if (mem_clr)
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        else if (ram_we)
            mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    task automatic wait_idle();
        for (int i = 0; i < 4 && gnt != 2'b00; i++) @(negedge CPUclk);
    endtask

    // One transaction on port p; lat = negedges from request to ack, wec = cycles with ram_we.
    task automatic txn(input int p, input logic we, input logic [7:0] a,
                       input logic [15:0] d, output int lat, output int wec);
        wait_idle();
        lat = -1;
        wec = 0;
        if (p == 0) begin
            r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
        end
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge CPUclk);
            if (ram_we) wec++;
            if ((p == 0) ? r0_ack : r1_ack) lat = c;
        end
        if (p == 0) r0_req = 1'b0; else r1_req = 1'b0;
    endtask

    task automatic run_tie(output logic [1:0] g0, output logic [1:0] g1,
                           output int t0, output int t1);
        logic [1:0] prev;
        int n;
        wait_idle();
        g0 = 2'b00; g1 = 2'b00; t0 = -1; t1 = -1; n = 0; prev = 2'b00;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h01;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h02;
        for (int c = 1; c <= 12 && (t0 < 0 || t1 < 0); c++) begin
            @(negedge CPUclk);
            if (gnt != 2'b00 && prev == 2'b00) begin
                if (n == 0) g0 = gnt; else if (n == 1) g1 = gnt;
                n++;
            end
            prev = gnt;
            if (r0_ack && t0 < 0) begin t0 = c; r0_req = 1'b0; end
            if (r1_ack && t1 < 0) begin t1 = c; r1_req = 1'b0; end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_clr = 1'b1;
        r0_req = 1'b1;
        repeat (3) @(negedge CPUclk);
        if ({ram_we, ram_addr, ram_wdata} !== 25'd0) begin
            bad++; $display("FAIL reset_ram: got we=%b addr=%h wdata=%h want 0", ram_we, ram_addr, ram_wdata);
        end
        total++;
        if ({r0_ack, r1_ack, gnt} !== 4'd0) begin
            bad++; $display("FAIL reset_ack_gnt: got %b want 0000", {r0_ack, r1_ack, gnt});
        end
        total++;
        if ({r0_rdata, r1_rdata} !== 32'd0) begin
            bad++; $display("FAIL reset_rdata: got %h %h want 0", r0_rdata, r1_rdata);
        end
        total++;
        r0_req = 1'b0;
        mem_clr = 1'b0;
        rst_n = 1'b1;
        @(negedge CPUclk);
    endtask

    task automatic test_tie();
        logic [1:0] g0, g1;
        int t0, t1;
        run_tie(g0, g1, t0, t1);
        if (g0 !== 2'b01) begin
            bad++; $display("FAIL tie_first: got gnt=%b want 01", g0);
        end
        total++;
        if (g1 !== 2'b10) begin
            bad++; $display("FAIL tie_second: got gnt=%b want 10", g1);
        end
        total++;
        if (t0 !== 2) begin
            bad++; $display("FAIL tie_lat0: got %0d want 2", t0);
        end
        total++;
        if (t1 - t0 !== 3) begin
            bad++; $display("FAIL tie_ack_gap: got %0d want 3", t1 - t0);
        end
        total++;
    endtask

    task automatic test_contention();
        logic [1:0] g [8];
        logic [1:0] prev;
        int n;
        wait_idle();
        n = 0;
        prev = 2'b00;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h03;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h04;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge CPUclk);
            if (gnt != 2'b00 && prev == 2'b00) begin
                g[n] = gnt;
                n++;
            end
            prev = gnt;
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i >= n || g[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL contention_grant%0d: got %b want %b", i, (i < n) ? g[i] : 2'bxx,
                                (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            total++;
        end
        wait_idle();
    endtask

    task automatic test_single_port0();
        int lat, wec;
        txn(0, 1'b1, 8'h10, 16'hBEEF, lat, wec);
        if (lat !== 2) begin
            bad++; $display("FAIL p0_write_lat: got %0d want 2", lat);
        end
        total++;
        if (wec !== 1) begin
            bad++; $display("FAIL p0_write_we_cycles: got %0d want 1", wec);
        end
        total++;
        txn(0, 1'b0, 8'h10, 16'h0000, lat, wec);
        if (lat !== 2) begin
            bad++; $display("FAIL p0_read_lat: got %0d want 2", lat);
        end
        total++;
        if (wec !== 0) begin
            bad++; $display("FAIL p0_read_we_cycles: got %0d want 0", wec);
        end
        total++;
        if (r0_rdata !== 16'hBEEF) begin
            bad++; $display("FAIL p0_read_data: got %h want beef", r0_rdata);
        end
        total++;
    endtask

    task automatic test_write_rdata();
        int lat, wec;
        txn(1, 1'b1, 8'h20, 16'h1234, lat, wec);
        txn(1, 1'b0, 8'h20, 16'h0000, lat, wec);
        if (r1_rdata !== 16'h1234) begin
            bad++; $display("FAIL p1_read_1234: got %h want 1234", r1_rdata);
        end
        total++;
        txn(1, 1'b1, 8'h20, 16'h5678, lat, wec);
        if (r1_ack !== 1'b1 || r1_rdata !== 16'h1234) begin
            bad++; $display("FAIL p1_rdata_at_write_ack: got ack=%b rdata=%h want 1 1234", r1_ack, r1_rdata);
        end
        total++;
        @(negedge CPUclk);
        if ({r1_ack, r1_rdata} !== {1'b0, 16'h1234}) begin
            bad++; $display("FAIL p1_rdata_after_write: got ack=%b rdata=%h want 0 1234", r1_ack, r1_rdata);
        end
        total++;
        txn(1, 1'b0, 8'h20, 16'h0000, lat, wec);
        if (r1_rdata !== 16'h5678) begin
            bad++; $display("FAIL p1_read_5678: got %h want 5678", r1_rdata);
        end
        total++;
    endtask

    task automatic test_reset_mid_serve();
        int lat, wec, acks;
        logic [1:0] g0, g1;
        int t0, t1;
        txn(0, 1'b1, 8'h30, 16'h5555, lat, wec);
        wait_idle();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h30; r0_wdata = 16'hAAAA;
        @(posedge CPUclk);
        #1;
        if ({ram_we, gnt} !== 3'b101) begin
            bad++; $display("FAIL mid_serve_entry: got we=%b gnt=%b want 1 01", ram_we, gnt);
        end
        total++;
        rst_n = 1'b0;
        #1;
        if ({ram_we, gnt} !== 3'b000) begin
            bad++; $display("FAIL mid_serve_reset_we: got we=%b gnt=%b want 0 00", ram_we, gnt);
        end
        total++;
        r0_req = 1'b0;
        acks = 0;
        @(negedge CPUclk);
        if (r0_ack) acks++;
        @(negedge CPUclk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge CPUclk);
            if (r0_ack) acks++;
        end
        if (acks !== 0) begin
            bad++; $display("FAIL mid_serve_no_ack: got %0d acks want 0", acks);
        end
        total++;
        if (mem[8'h30] !== 16'h5555) begin
            bad++; $display("FAIL mid_serve_mem: got %h want 5555", mem[8'h30]);
        end
        total++;
        run_tie(g0, g1, t0, t1);
        if (g0 !== 2'b01) begin
            bad++; $display("FAIL mid_serve_tie: got gnt=%b want 01", g0);
        end
        total++;
        txn(0, 1'b0, 8'h30, 16'h0000, lat, wec);
        if (r0_rdata !== 16'h5555) begin
            bad++; $display("FAIL mid_serve_readback: got %h want 5555", r0_rdata);
        end
        total++;
    endtask

    task automatic test_wrap();
        int lat, wec;
        txn(1, 1'b1, 8'h00, 16'h7777, lat, wec);
        txn(0, 1'b1, 8'hFF, 16'h0001, lat, wec);
        txn(0, 1'b0, 8'hFF, 16'h0000, lat, wec);
        if (r0_rdata !== 16'h0001) begin
            bad++; $display("FAIL wrap_read_ff: got %h want 0001", r0_rdata);
        end
        total++;
        txn(1, 1'b0, 8'h00, 16'h0000, lat, wec);
        if (r1_rdata !== 16'h7777) begin
            bad++; $display("FAIL wrap_read_00: got %h want 7777", r1_rdata);
        end
        total++;
        if (lat !== 2) begin
            bad++; $display("FAIL wrap_lat: got %0d want 2", lat);
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_tie();
        test_contention();
        test_single_port0();
        test_write_rdata();
        test_reset_mid_serve();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
